fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC loaded on reset; bits [1:0] SHALL be treated as zero.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries; legal values are 2 and 4.
REQ-003 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 o_mem_req  out  1  instruction-memory read request.
REQ-006 o_mem_addr  out  64  request byte address, word-aligned.
REQ-007 i_mem_ack  in  1  memory accepted the request this cycle.
REQ-008 i_mem_rvalid  in  1  read data valid for the single outstanding request.
REQ-009 i_mem_rdata  in  32  instruction word.
REQ-010 o_insn_valid  out  1  buffer head holds an instruction for the decoder.
REQ-011 o_insn  out  32  buffer head instruction; feeds the decoder instruction input.
REQ-012 o_insn_pc  out  64  address of o_insn.
REQ-013 i_insn_ready  in  1  decoder consumes the head this cycle.
REQ-014 i_redirect  in  1  flush and restart fetch at i_redirect_pc.
REQ-015 i_redirect_pc  in  64  new fetch address; bits [1:0] SHALL be ignored and forced to 0.
REQ-016 i_halt  in  1  decoder reached HALT; stop fetching.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DROP, HALTED.
REQ-018 At most one memory request SHALL be outstanding at any time.
REQ-019 IDLE->REQ when (count + 0) < DEPTH; o_mem_req SHALL be 1 exactly while in REQ.
REQ-020 o_mem_addr SHALL equal the PC and SHALL hold stable while o_mem_req=1 and i_mem_ack=0.
REQ-021 REQ with i_mem_ack=1 -> WAIT; PC += 4 (64-bit wrap, FFFF_FFFF_FFFF_FFFC+4 = 0); the request address SHALL be latched as req_pc.
REQ-022 WAIT with i_mem_rvalid=1 -> IDLE; {i_mem_rdata, req_pc} SHALL be pushed to the buffer tail.
REQ-023 i_mem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-024 The buffer SHALL be a FIFO; count ranges 0..DEPTH; o_insn_valid = (count != 0); o_insn/o_insn_pc SHALL come from registers.
REQ-025 A pop SHALL occur when o_insn_valid & i_insn_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-026 A word pushed into an empty buffer SHALL appear on o_insn_valid the cycle after i_mem_rvalid; there is no bypass.
REQ-027 Request issue SHALL guarantee no push when full: REQ is entered only if count < DEPTH, counting a pop in the same cycle as freeing space.
REQ-028 i_redirect=1 has highest priority.
REQ-029 On redirect, count <- 0 and PC <- i_redirect_pc.
REQ-030 Redirect state transitions: WAIT, or REQ with i_mem_ack=1, -> DROP; REQ without ack, IDLE, or HALTED -> IDLE.
REQ-031 A pop coinciding with a redirect SHALL count as consumed; the flush still empties the buffer.
REQ-032 DROP SHALL discard the next i_mem_rvalid without pushing, then -> IDLE; a new request SHALL NOT issue while in DROP.
REQ-033 i_halt=1 with i_redirect=0 SHALL cause: WAIT->DROP-then-HALTED, i.e. the response is discarded and the FSM enters HALTED.
REQ-034 i_halt=1 with i_redirect=0 SHALL cause: REQ without ack, or IDLE, -> HALTED.
REQ-035 i_halt=1 with i_redirect=0 SHALL cause: REQ with i_mem_ack=1 -> WAIT, then handled as the WAIT case.
REQ-036 The buffer SHALL be preserved on halt.
REQ-037 HALTED SHALL issue no requests; only reset or redirect SHALL leave HALTED.
REQ-038 Simultaneous i_redirect and i_halt SHALL be treated as redirect only.

Reset
REQ-039 i_rst_n=0 SHALL immediately force: state IDLE, PC=RESET_PC, count=0, o_mem_req=0, o_insn_valid=0, o_insn=0, o_insn_pc=0, o_mem_addr=RESET_PC, halt-pending=0.
REQ-040 After i_rst_n rises, o_mem_req SHALL assert on the cycle following the first rising edge.
REQ-041 Reset asserted mid-request SHALL abandon any outstanding response, and a late i_mem_rvalid in IDLE SHALL be ignored.

Verification
REQ-042 Reset release, memory acks immediately, data one cycle later (words 0x5000_0000, 0x5000_0001), ready=1 -> o_insn_pc sequence 0, 4, and o_insn matches the words in order.
REQ-043 i_insn_ready=0, DEPTH=2 -> exactly 2 acks; o_mem_req stays 0 afterwards and count=2; raising ready for one cycle -> exactly one further request, at addr 8.
REQ-044 i_redirect with pc 0x1003 while in WAIT -> the pending rvalid is dropped, o_insn_valid=0 next cycle, the next o_mem_addr=0x1000, and the first delivered o_insn_pc=0x1000.
REQ-045 i_halt while in WAIT -> the response is discarded and o_mem_req stays 0 for 20 cycles; a later redirect to 0x40 resumes fetch at 0x40.
REQ-046 i_halt and i_redirect (0x80) in the same cycle -> fetch resumes at 0x80 and the FSM does not enter HALTED.
REQ-047 i_rst_n dropped while o_mem_req=1 -> o_mem_req=0 asynchronously; an rvalid 1 cycle after release -> not pushed, o_insn_valid stays 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module  : fetch_unit_if
// Purpose : Instruction-memory and decoder-facing signals of the fetch unit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    logic        o_mem_req;
    logic [63:0] o_mem_addr;
    logic        i_mem_ack;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_insn_valid;
    logic [31:0] o_insn;
    logic [63:0] o_insn_pc;
    logic        i_insn_ready;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        i_halt;

    modport master (
        output o_mem_req, o_mem_addr, o_insn_valid, o_insn, o_insn_pc,
        input  i_mem_ack, i_mem_rvalid, i_mem_rdata, i_insn_ready,
        input  i_redirect, i_redirect_pc, i_halt
    );

    modport slave (
        input  o_mem_req, o_mem_addr, o_insn_valid, o_insn, o_insn_pc,
        output i_mem_ack, i_mem_rvalid, i_mem_rdata, i_insn_ready,
        output i_redirect, i_redirect_pc, i_halt
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Purpose : Single-outstanding instruction fetcher feeding a small FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst_n,
    fetch_unit_if.master   bus
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [63:0]   c_RESET_PC = {RESET_PC[63:2], 2'b00};
    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DROP   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [63:0]    r_pc;
    logic [63:0]    r_req_pc;
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic           r_halt_pend;
    logic           w_halt_pend_nxt;
    logic           w_push;
    logic           w_pop;
    logic           w_space;
    logic           w_accept;
    logic [31:0]    r_insn_mem [DEPTH];
    logic [63:0]    r_pc_mem   [DEPTH];

    assign w_pop    = (r_count != '0) && bus.i_insn_ready;
    // A same-cycle pop frees a slot before the new response can return.
    assign w_space  = (r_count < c_DEPTH) || w_pop;
    assign w_accept = (r_state == S_REQ) && bus.i_mem_ack;

    assign bus.o_mem_req    = (r_state == S_REQ);
    assign bus.o_mem_addr   = r_pc;
    assign bus.o_insn_valid = (r_count != '0);
    assign bus.o_insn       = r_insn_mem[r_rd_ptr];
    assign bus.o_insn_pc    = r_pc_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_halt_pend_nxt = r_halt_pend;
        w_push          = 1'b0;
        if (bus.i_redirect) begin
            w_halt_pend_nxt = 1'b0;
            case (r_state)
                S_WAIT:  w_state_nxt = bus.i_mem_rvalid ? S_IDLE : S_DROP;
                S_REQ:   w_state_nxt = bus.i_mem_ack ? S_DROP : S_IDLE;
                S_DROP:  w_state_nxt = bus.i_mem_rvalid ? S_IDLE : S_DROP;
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_halt)   w_state_nxt = S_HALTED;
                    else if (w_space) w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (bus.i_mem_ack) begin
                        w_state_nxt = S_WAIT;
                        if (bus.i_halt) w_halt_pend_nxt = 1'b1;
                    end else if (bus.i_halt) begin
                        w_state_nxt = S_HALTED;
                    end
                end
                S_WAIT: begin
                    // A halt discards the in-flight word whether or not it arrives now.
                    if (bus.i_halt || r_halt_pend) begin
                        if (bus.i_mem_rvalid) begin
                            w_state_nxt     = S_HALTED;
                            w_halt_pend_nxt = 1'b0;
                        end else begin
                            w_state_nxt     = S_DROP;
                            w_halt_pend_nxt = 1'b1;
                        end
                    end else if (bus.i_mem_rvalid) begin
                        w_state_nxt = S_IDLE;
                        w_push      = 1'b1;
                    end
                end
                S_DROP: begin
                    if (bus.i_halt) w_halt_pend_nxt = 1'b1;
                    if (bus.i_mem_rvalid) begin
                        w_state_nxt     = (bus.i_halt || r_halt_pend) ? S_HALTED : S_IDLE;
                        w_halt_pend_nxt = 1'b0;
                    end
                end
                S_HALTED: w_state_nxt = S_HALTED;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc        <= c_RESET_PC;
            r_req_pc    <= '0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_halt_pend <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_insn_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
        end else begin
            r_halt_pend <= w_halt_pend_nxt;
            if (bus.i_redirect) begin
                r_pc     <= {bus.i_redirect_pc[63:2], 2'b00};
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_accept) begin
                    r_req_pc <= r_pc;
                    r_pc     <= r_pc + 64'd4;
                end
                if (w_push) begin
                    r_insn_mem[r_wr_ptr] <= bus.i_mem_rdata;
                    r_pc_mem[r_wr_ptr]   <= r_req_pc;
                    r_wr_ptr             <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed self-checking bench for fetch_unit (DEPTH=2, RESET_PC=0).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Memory model state: immediate ack, response after 'lat' cycles.
    bit          auto_mem;
    bit          force_rvalid;
    bit          resp_pending;
    int          resp_wait;
    int          lat;
    logic [31:0] resp_data;
    int          word_idx;
    logic [63:0] acked[$];
    logic [63:0] got_pc[$];
    logic [31:0] got_insn[$];

    task automatic cyc();
        bit ack_now;
        ack_now = 1'b0;
        bus.i_mem_ack    = auto_mem && bus.o_mem_req;
        bus.i_mem_rvalid = force_rvalid || (resp_pending && resp_wait == 0);
        bus.i_mem_rdata  = force_rvalid ? 32'hDEAD_BEEF : resp_data;
        if (rst_n) begin
            if (bus.o_mem_req && bus.i_mem_ack) begin
                acked.push_back(bus.o_mem_addr);
                ack_now = 1'b1;
            end
            if (bus.o_insn_valid && bus.i_insn_ready) begin
                got_pc.push_back(bus.o_insn_pc);
                got_insn.push_back(bus.o_insn);
            end
        end
        @(posedge clk);
        if (bus.i_mem_rvalid)  resp_pending = 1'b0;
        else if (resp_pending) resp_wait--;
        if (ack_now) begin
            resp_pending = 1'b1;
            resp_wait    = lat - 1;
            resp_data    = 32'h5000_0000 + word_idx;
            word_idx++;
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        resp_pending = 1'b0;
        resp_wait    = 0;
        resp_data    = '0;
        word_idx     = 0;
        force_rvalid = 1'b0;
        acked.delete();
        got_pc.delete();
        got_insn.delete();
    endtask

    // Leaves the bench just after a negedge with reset released and the DUT in IDLE.
    task automatic do_reset();
        rst_n                = 1'b0;
        auto_mem             = 1'b1;
        lat                  = 1;
        bus.i_mem_ack        = 1'b0;
        bus.i_mem_rvalid     = 1'b0;
        bus.i_mem_rdata      = '0;
        bus.i_insn_ready     = 1'b0;
        bus.i_redirect       = 1'b0;
        bus.i_redirect_pc    = '0;
        bus.i_halt           = 1'b0;
        clear_model();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        auto_mem = 1'b0;
        cyc();
        checks++; if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.o_mem_req); end
        checks++; if (bus.o_mem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.o_mem_addr); end
        checks++; if (bus.o_insn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_insn_valid); end
        checks++; if (bus.o_insn !== 32'h0) begin errors++; $display("FAIL reset_insn: got %h want 0", bus.o_insn); end
        checks++; if (bus.o_insn_pc !== 64'h0) begin errors++; $display("FAIL reset_insn_pc: got %h want 0", bus.o_insn_pc); end
        rst_n = 1'b1;
        cyc();
        checks++; if (bus.o_mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.o_mem_req); end
        cyc();
        checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 64'h0) begin
            errors++; $display("FAIL req_hold: got req=%b addr=%h want req=1 addr=0", bus.o_mem_req, bus.o_mem_addr);
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus.i_insn_ready = 1'b1;
        for (int k = 0; k < 40 && got_pc.size() < 2; k++) cyc();
        checks++;
        if (got_pc.size() < 2) begin
            errors++; $display("FAIL basic_timeout: got %0d insns want 2", got_pc.size());
        end else begin
            if (got_pc[0] !== 64'h0 || got_pc[1] !== 64'h4) begin
                errors++; $display("FAIL basic_pc: got %h,%h want 0,4", got_pc[0], got_pc[1]);
            end
            checks++;
            if (got_insn[0] !== 32'h5000_0000 || got_insn[1] !== 32'h5000_0001) begin
                errors++; $display("FAIL basic_insn: got %h,%h want 50000000,50000001", got_insn[0], got_insn[1]);
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        bus.i_insn_ready = 1'b0;
        repeat (20) cyc();
        checks++; if (acked.size() != 2) begin errors++; $display("FAIL full_acks: got %0d want 2", acked.size()); end
        checks++; if (bus.o_mem_req !== 1'b0 || bus.o_insn_valid !== 1'b1) begin
            errors++; $display("FAIL full_idle: got req=%b valid=%b want req=0 valid=1", bus.o_mem_req, bus.o_insn_valid);
        end
        bus.i_insn_ready = 1'b1;
        cyc();
        bus.i_insn_ready = 1'b0;
        repeat (20) cyc();
        checks++;
        if (acked.size() != 3) begin
            errors++; $display("FAIL full_refill: got %0d acks want 3", acked.size());
        end else if (acked[2] !== 64'h8) begin
            errors++; $display("FAIL full_refill: got addr %h want 8", acked[2]);
        end
        checks++; if (bus.o_insn_pc !== 64'h4 || bus.o_mem_req !== 1'b0) begin
            errors++; $display("FAIL full_head: got pc=%h req=%b want pc=4 req=0", bus.o_insn_pc, bus.o_mem_req);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 20 && acked.size() < 1; k++) cyc();
        lat = 3;
        for (int k = 0; k < 20 && acked.size() < 2; k++) cyc();
        checks++; if (bus.o_insn_valid !== 1'b1) begin errors++; $display("FAIL redir_pre_valid: got %b want 1", bus.o_insn_valid); end
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h1003;
        cyc();
        bus.i_redirect   = 1'b0;
        bus.i_insn_ready = 1'b1;
        checks++; if (bus.o_insn_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", bus.o_insn_valid); end
        checks++; if (bus.o_mem_addr !== 64'h1000 || bus.o_mem_req !== 1'b0) begin
            errors++; $display("FAIL redir_drop: got addr=%h req=%b want 1000,0", bus.o_mem_addr, bus.o_mem_req);
        end
        for (int k = 0; k < 40 && got_pc.size() < 1; k++) cyc();
        checks++;
        if (got_pc.size() < 1) begin
            errors++; $display("FAIL redir_timeout: got 0 insns want 1");
        end else if (got_pc[0] !== 64'h1000 || got_insn[0] !== 32'h5000_0002) begin
            errors++; $display("FAIL redir_first: got pc=%h insn=%h want 1000,50000002", got_pc[0], got_insn[0]);
        end
    endtask

    task automatic test_halt();
        int req_seen;
        req_seen = 0;
        do_reset();
        for (int k = 0; k < 20 && acked.size() < 1; k++) cyc();
        lat = 3;
        for (int k = 0; k < 20 && acked.size() < 2; k++) cyc();
        lat = 1;
        bus.i_halt = 1'b1;
        cyc();
        bus.i_halt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (bus.o_mem_req) req_seen++;
        end
        checks++; if (req_seen != 0 || acked.size() != 2) begin
            errors++; $display("FAIL halt_quiet: got %0d req cycles, %0d acks want 0, 2", req_seen, acked.size());
        end
        checks++; if (bus.o_insn_valid !== 1'b1 || bus.o_insn_pc !== 64'h0 || bus.o_insn !== 32'h5000_0000) begin
            errors++; $display("FAIL halt_keep: got valid=%b pc=%h insn=%h want 1,0,50000000",
                               bus.o_insn_valid, bus.o_insn_pc, bus.o_insn);
        end
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h40;
        cyc();
        bus.i_redirect   = 1'b0;
        bus.i_insn_ready = 1'b1;
        for (int k = 0; k < 40 && got_pc.size() < 1; k++) cyc();
        checks++;
        if (got_pc.size() < 1) begin
            errors++; $display("FAIL halt_resume_timeout: got 0 insns want 1");
        end else if (got_pc[0] !== 64'h40 || got_insn[0] !== 32'h5000_0002) begin
            errors++; $display("FAIL halt_resume: got pc=%h insn=%h want 40,50000002", got_pc[0], got_insn[0]);
        end
    endtask

    task automatic test_halt_redirect();
        do_reset();
        bus.i_insn_ready = 1'b1;
        cyc();
        bus.i_halt        = 1'b1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'h80;
        cyc();
        bus.i_halt     = 1'b0;
        bus.i_redirect = 1'b0;
        for (int k = 0; k < 40 && got_pc.size() < 1; k++) cyc();
        checks++;
        if (got_pc.size() < 1) begin
            errors++; $display("FAIL halt_redir_timeout: got 0 insns want 1");
        end else if (got_pc[0] !== 64'h80 || got_insn[0] !== 32'h5000_0001) begin
            errors++; $display("FAIL halt_redir: got pc=%h insn=%h want 80,50000001", got_pc[0], got_insn[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_insn_ready = 1'b1;
        cyc();
        checks++; if (bus.o_mem_req !== 1'b1) begin errors++; $display("FAIL rmid_pre: got req=%b want 1", bus.o_mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_mem_req !== 1'b0 || bus.o_mem_addr !== 64'h0) begin
            errors++; $display("FAIL rmid_async: got req=%b addr=%h want 0,0", bus.o_mem_req, bus.o_mem_addr);
        end
        clear_model();
        @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        auto_mem     = 1'b0;
        force_rvalid = 1'b1;
        cyc();
        force_rvalid = 1'b0;
        checks++; if (bus.o_insn_valid !== 1'b0) begin errors++; $display("FAIL rmid_late1: got valid=%b want 0", bus.o_insn_valid); end
        cyc();
        checks++; if (bus.o_insn_valid !== 1'b0 || bus.o_mem_req !== 1'b1) begin
            errors++; $display("FAIL rmid_late2: got valid=%b req=%b want 0,1", bus.o_insn_valid, bus.o_mem_req);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.i_insn_ready  = 1'b1;
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc();
        bus.i_redirect = 1'b0;
        for (int k = 0; k < 40 && got_pc.size() < 2; k++) cyc();
        checks++;
        if (got_pc.size() < 2) begin
            errors++; $display("FAIL wrap_timeout: got %0d insns want 2", got_pc.size());
        end else if (got_pc[0] !== 64'hFFFF_FFFF_FFFF_FFFC || got_pc[1] !== 64'h0) begin
            errors++; $display("FAIL wrap_pc: got %h,%h want fffffffffffffffc,0", got_pc[0], got_pc[1]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_redirect();
        test_halt();
        test_halt_redirect();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
